alu_mdu: RTL and testbench

//  Sequential execute unit: the base RV32I ALU ops plus the RV32M mul/div/rem ops,

---
 rtl/alu_mdu_pkg.sv | 43 ++++
 rtl/alu_mdu_if.sv | 27 ++
 rtl/alu_mdu_alu.sv | 37 +++
 rtl/alu_mdu_div_iter.sv | 57 +++++
 rtl/alu_mdu.sv | 170 +++++++++++++++++
 tb/tb_alu_mdu.sv | 270 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared types for the alu_mdu execute unit:
// op encodings, FSM states and op-class helpers.
package alu_mdu_pkg;

    localparam int XLEN      = 32;
    localparam int MDU_CNT_W = $clog2(XLEN);

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        MDU_MUL    = 5'd16,
        MDU_MULH   = 5'd17,
        MDU_MULHSU = 5'd18,
        MDU_MULHU  = 5'd19,
        MDU_DIV    = 5'd20,
        MDU_DIVU   = 5'd21,
        MDU_REM    = 5'd22,
        MDU_REMU   = 5'd23
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mdu_state_t;

    function automatic logic is_mul(mdu_op_t op);
        return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU};
    endfunction

    function automatic logic is_div(mdu_op_t op);
        return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Valid/ready request and response bundle of the execute unit.
// The unit itself connects through the slave modport.
interface alu_mdu_if #(
    parameter int DATA_WIDTH = 32
);
    import alu_mdu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    mdu_op_t               op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output in_valid, operand1, operand2, op, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, operand1, operand2, op, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/alu_mdu_alu.sv
// Combinational RV32I base ALU.
module alu_mdu_alu import alu_mdu_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  mdu_op_t               op_i,
    output logic [DATA_WIDTH-1:0] y_o
);
    localparam int SW = $clog2(DATA_WIDTH);

    logic [SW-1:0] shamt;
    logic          lt_s;
    logic          lt_u;

    assign shamt = b_i[SW-1:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SLT:  y_o = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: y_o = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_mdu_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one step per cycle.
// quot_o/rem_o show the values produced by the step taken this cycle.
module alu_mdu_div_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] quot_o,
    output logic [DATA_WIDTH-1:0] rem_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    logic          run_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  dvs_q;
    logic [W:0]    shl;
    logic [W:0]    diff;

    // Partial remainder stays below the divisor, so W+1 bits hold the shift.
    assign shl    = {rem_q, quo_q[W-1]};
    assign diff   = shl - {1'b0, dvs_q};
    assign rem_o  = diff[W] ? shl[W-1:0] : diff[W-1:0];
    assign quot_o = {quo_q[W-2:0], ~diff[W]};
    assign done_o = run_q && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (abort_i) begin
            run_q <= 1'b0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= CW'(W - 1);
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else if (run_q) begin
            quo_q <= quot_o;
            rem_q <= rem_o;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execute unit: RV32I ALU plus RV32M mul/div/rem
// behind a valid/ready handshake, single-cycle or iterative.
module alu_mdu import alu_mdu_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter bit FAST_MUL   = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    input logic         flush,
    alu_mdu_if.slave    bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

    mdu_state_t    state_q;
    mdu_op_t       op_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  res_q;
    logic [W-1:0]  ma_q;
    logic          an_q;
    logic          bn_q;
    logic [2*W-1:0] prod_q;

    logic [W-1:0] a, b;
    logic         a_sgn, b_sgn, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic         div_zero, div_ovf, div_spec, is_rem_in;
    logic         accept, go_iter, div_start;

    assign a = bus.operand1;
    assign b = bus.operand2;

    always_comb begin
        a_sgn = bus.op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
        b_sgn = bus.op inside {MDU_MULH, MDU_DIV, MDU_REM};
        a_neg = a_sgn & a[W-1];
        b_neg = b_sgn & b[W-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    assign is_rem_in = bus.op inside {MDU_REM, MDU_REMU};
    assign div_zero  = (b == '0);
    assign div_ovf   = (bus.op inside {MDU_DIV, MDU_REM}) &&
                       (a == MIN_INT) && (b == '1);
    assign div_spec  = div_zero | div_ovf;
    assign accept    = (state_q == IDLE) && bus.in_valid && !flush;
    assign go_iter   = (is_mul(bus.op) && !FAST_MUL) ||
                       (is_div(bus.op) && !div_spec);
    assign div_start = accept && is_div(bus.op) && !div_spec;

    logic [W-1:0] alu_y;

    alu_mdu_alu #(.DATA_WIDTH(W)) u_alu (
        .a_i  (a),
        .b_i  (b),
        .op_i (bus.op),
        .y_o  (alu_y)
    );

    logic         div_done;
    logic [W-1:0] div_q, div_r;

    alu_mdu_div_iter #(.DATA_WIDTH(W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort_i    (flush),
        .start_i    (div_start),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .done_o     (div_done),
        .quot_o     (div_q),
        .rem_o      (div_r)
    );

    // Sign-extended to 2W, the low 2W bits of the product are exact.
    logic signed [W:0] sa, sb;
    logic [2*W-1:0]    fprod;

    assign sa    = {a_sgn & a[W-1], a};
    assign sb    = {b_sgn & b[W-1], b};
    assign fprod = (2*W)'(sa) * (2*W)'(sb);

    logic [W-1:0] fast_res;

    always_comb begin
        fast_res = alu_y;
        unique case (1'b1)
            is_mul(bus.op):
                fast_res = (bus.op == MDU_MUL) ? fprod[W-1:0]
                                               : fprod[2*W-1:W];
            is_div(bus.op) && div_zero:
                fast_res = is_rem_in ? a : '1;
            is_div(bus.op) && div_ovf:
                fast_res = is_rem_in ? '0 : MIN_INT;
            default: ;
        endcase
    end

    logic [W:0]     msum;
    logic [2*W-1:0] prod_d;
    logic [2*W-1:0] psgn;
    logic [W-1:0]   iter_res;

    // Shift-add on magnitudes; the sign is applied once the product is whole.
    assign msum   = {1'b0, prod_q[2*W-1:W]} +
                    (prod_q[0] ? {1'b0, ma_q} : '0);
    assign prod_d = {msum, prod_q[W-1:1]};
    assign psgn   = (an_q ^ bn_q) ? -prod_d : prod_d;

    always_comb begin
        iter_res = '0;
        unique case (1'b1)
            is_mul(op_q):
                iter_res = (op_q == MDU_MUL) ? psgn[W-1:0] : psgn[2*W-1:W];
            op_q inside {MDU_REM, MDU_REMU}:
                iter_res = an_q ? -div_r : div_r;
            default:
                iter_res = (an_q ^ bn_q) ? -div_q : div_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= ALU_ADD;
            cnt_q   <= '0;
            res_q   <= '0;
            ma_q    <= '0;
            an_q    <= 1'b0;
            bn_q    <= 1'b0;
            prod_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    op_q   <= bus.op;
                    an_q   <= a_neg;
                    bn_q   <= b_neg;
                    ma_q   <= a_mag;
                    prod_q <= {{W{1'b0}}, b_mag};
                    cnt_q  <= CW'(W - 1);
                    if (go_iter) begin
                        state_q <= BUSY;
                    end else begin
                        state_q <= DONE;
                        res_q   <= fast_res;
                    end
                end
                BUSY: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (is_mul(op_q) ? (cnt_q == '0) : div_done) begin
                        state_q <= DONE;
                        res_q   <= iter_res;
                    end
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: fast and iterative multiplier builds driven in lockstep,
// expected results queued at issue and compared when out_valid appears.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    mdu_op_t     op = ALU_ADD;

    int checks = 0;
    int errors = 0;
    logic [31:0] q_exp[$];

    always #5 clk = ~clk;

    alu_mdu_if #(.DATA_WIDTH(32)) if_f ();
    alu_mdu_if #(.DATA_WIDTH(32)) if_s ();

    assign if_f.in_valid  = in_valid;
    assign if_f.operand1  = op1;
    assign if_f.operand2  = op2;
    assign if_f.op        = op;
    assign if_f.out_ready = out_ready;
    assign if_s.in_valid  = in_valid;
    assign if_s.operand1  = op1;
    assign if_s.operand2  = op2;
    assign if_s.op        = op;
    assign if_s.out_ready = out_ready;

    alu_mdu #(.DATA_WIDTH(32), .FAST_MUL(1'b1)) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (if_f)
    );

    alu_mdu #(.DATA_WIDTH(32), .FAST_MUL(1'b0)) u_slow (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (if_s)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(mdu_op_t o, logic [31:0] a,
                                          logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        r = '0;
        case (o)
            ALU_ADD:    r = a + b;
            ALU_SUB:    r = a - b;
            ALU_XOR:    r = a ^ b;
            MDU_MUL: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[31:0];
            end
            MDU_MULHU: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[63:32];
            end
            MDU_MULH: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r = p[63:32];
            end
            MDU_MULHSU: begin
                p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                r = p[63:32];
            end
            MDU_DIVU:   r = (b == 0) ? '1 : a / b;
            MDU_REMU:   r = (b == 0) ? a : a % b;
            MDU_DIV: begin
                if (b == 0) r = '1;
                else if (a == MIN && b == '1) r = MIN;
                else r = $signed(a) / $signed(b);
            end
            MDU_REM: begin
                if (b == 0) r = a;
                else if (a == MIN && b == '1) r = '0;
                else r = $signed(a) % $signed(b);
            end
            default:    r = '0;
        endcase
        return r;
    endfunction

    task automatic issue(input mdu_op_t o, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        op = o;
        op1 = a;
        op2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("rdy_back", {if_f.in_ready, if_s.in_ready, if_f.out_valid,
                         if_s.out_valid}, 4'b1100);
    endtask

    task automatic run_op(input mdu_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e);
        int lf, ls, n, ef, es;
        logic [31:0] x;
        ef = 1;
        es = 1;
        if (o inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU}) es = 33;
        if ((o inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU}) && b != 0 &&
            !((o inside {MDU_DIV, MDU_REM}) && a == MIN && b == '1)) begin
            ef = 33;
            es = 33;
        end
        q_exp.push_back(e);
        issue(o, a, b);
        lf = 0;
        ls = 0;
        n = 1;
        while ((lf == 0 || ls == 0) && n < 100) begin
            if (lf == 0 && if_f.out_valid) lf = n;
            if (ls == 0 && if_s.out_valid) ls = n;
            if (lf == 0 || ls == 0) begin
                @(posedge clk);
                #1 n++;
            end
        end
        x = q_exp.pop_front();
        chk($sformatf("%s res_fast", o.name()), if_f.result, x);
        chk($sformatf("%s res_iter", o.name()), if_s.result, x);
        chk($sformatf("%s lat_fast", o.name()), lf, ef);
        chk($sformatf("%s lat_iter", o.name()), ls, es);
        drain();
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1 seen = seen | if_f.out_valid | if_s.out_valid;
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        mdu_op_t rops[10];
        logic [31:0] ra, rb;
        mdu_op_t ro;
        rops = '{MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_DIV,
                 MDU_DIVU, MDU_REM, MDU_REMU, ALU_ADD, ALU_XOR};

        #12;
        chk("reset", {if_f.in_ready, if_s.in_ready, if_f.out_valid,
                      if_s.out_valid, if_f.result, if_s.result},
            {4'b1100, 64'h0});
        @(negedge clk);
        rst_n = 1'b1;

        run_op(ALU_ADD,  32'd7,   32'd5,        32'd12);
        run_op(ALU_SUB,  32'd3,   32'd5,        32'hFFFF_FFFE);
        run_op(ALU_SLL,  32'd1,   32'd35,       32'd8);
        run_op(ALU_SRA,  MIN,     32'd4,        32'hF800_0000);
        run_op(ALU_SRL,  MIN,     32'd4,        32'h0800_0000);
        run_op(ALU_SLT,  32'd1,   32'hFFFF_FFFF, 32'd0);
        run_op(ALU_SLTU, 32'd1,   32'hFFFF_FFFF, 32'd1);
        run_op(ALU_AND,  32'hF0F0, 32'hFF00,    32'hF000);
        run_op(ALU_OR,   32'hF0F0, 32'h0F00,    32'hFFF0);

        run_op(MDU_DIV,  -32'sd20, 32'd3,       32'hFFFF_FFFA);
        run_op(MDU_REM,  -32'sd20, 32'd3,       32'hFFFF_FFFE);
        run_op(MDU_DIV,  32'd20,  -32'sd3,      32'hFFFF_FFFA);
        run_op(MDU_REM,  32'd20,  -32'sd3,      32'd2);
        run_op(MDU_DIVU, 32'd100, 32'd7,        32'd14);
        run_op(MDU_REMU, 32'd100, 32'd7,        32'd2);
        run_op(MDU_DIVU, 32'd1234, 32'd0,       32'hFFFF_FFFF);
        run_op(MDU_REMU, 32'd5,   32'd0,        32'd5);
        run_op(MDU_REM,  MIN,     32'hFFFF_FFFF, 32'd0);
        run_op(MDU_DIV,  MIN,     32'hFFFF_FFFF, MIN);

        run_op(MDU_MULH,   MIN,   MIN,           32'h4000_0000);
        run_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(MDU_MUL,    32'd7, -32'sd3,       32'hFFFF_FFEB);
        run_op(MDU_MULH,   -32'sd3, 32'd7,       32'hFFFF_FFFF);

        for (int i = 0; i < 12; i++) begin
            ro = rops[$urandom_range(0, 9)];
            ra = $urandom;
            rb = $urandom;
            run_op(ro, ra, rb, model(ro, ra, rb));
        end

        // Result must hold while the consumer stalls; new requests are ignored.
        q_exp.push_back(32'd12);
        issue(ALU_ADD, 32'd7, 32'd5);
        @(negedge clk);
        op = ALU_SUB;
        op1 = 32'd100;
        op2 = 32'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 chk($sformatf("hold%0d", i),
                   {if_f.out_valid, if_s.out_valid, if_f.in_ready,
                    if_s.in_ready, if_f.result, if_s.result},
                   {4'b1100, q_exp[0], q_exp[0]});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        void'(q_exp.pop_front());
        chk("hold_release", {if_f.in_ready, if_s.in_ready}, 2'b11);

        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (16) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 chk("flush_idle", {if_f.in_ready, if_s.in_ready,
                              if_f.out_valid, if_s.out_valid}, 4'b1100);
        @(negedge clk);
        flush = 1'b0;
        watch_quiet("flush_quiet", 40);
        run_op(ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);

        issue(MDU_DIVU, 32'd999, 32'd10);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {if_f.in_ready, if_s.in_ready, if_f.out_valid,
                             if_s.out_valid, if_f.result, if_s.result},
               {4'b1100, 64'h0});
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("rst_quiet", 40);
        run_op(ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
        run_op(MDU_DIV, -32'sd20, 32'd3, 32'hFFFF_FFFA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
